nic_port_map_lookup: RTL and testbench
======================================

Name: nic_port_map_lookup

Overview:
Parametrised output-port lookup stage for the N-port NIC datapath. It sits between the input arbiter and the output queues. It rewrites the destination one-hot in the IOQ module header so that each MAC port is paired with its CPU DMA port, with an optional loopback mode. It also drops packets from invalid or disabled sources and exposes control and counters on the UDP register chain.

Parameters:
DATA_WIDTH, 64, datapath width in bits
CTRL_WIDTH, DATA_WIDTH/8, ctrl width
UDP_REG_SRC_WIDTH, 2, register source tag width
NUM_PORT_PAIRS, 4, MAC/CPU port pairs; legal range 1..8
IO_QUEUE_STAGE_NUM, 8'hFF, ctrl value that marks the IOQ header word
IOQ_SRC_PORT_POS, 16, LSB of the 16-bit source-port field
IOQ_DST_PORT_POS, 48, LSB of the 16-bit destination one-hot field
FIFO_DEPTH_BITS, 2, log2 of the output FIFO depth
BLOCK_ADDR, 'h0, block tag compared against reg_addr_in[29:REG_ADDR_BITS]
REG_ADDR_BITS, 2, width of the in-block word offset

Ports:
clk  in  1  clock
reset  in  1  synchronous, active-high
in_data  in  DATA_WIDTH  input word
in_ctrl  in  CTRL_WIDTH  input ctrl
in_wr  in  1  input word valid
in_rdy  out  1  =!fifo_nearly_full
out_data  out  DATA_WIDTH  FIFO head data
out_ctrl  out  CTRL_WIDTH  FIFO head ctrl
out_wr  out  1  output word valid, registered
out_rdy  in  1  downstream can accept
reg_req_in / reg_ack_in / reg_rd_wr_L_in  in  1 each  register chain inputs
reg_addr_in  in  30  register address
reg_data_in  in  32  register data
reg_src_in  in  UDP_REG_SRC_WIDTH  register source tag
reg_req_out / reg_ack_out / reg_rd_wr_L_out / reg_addr_out / reg_data_out / reg_src_out  out  same widths  registered chain outputs

Behaviour:
- Reset: state=HDRS, FIFO empty, out_wr=0, all reg_*_out=0, CTRL = {enable mask all ones, loopback=0}, both counters 0.
- Output side: rd_en = out_rdy && !empty; out_wr <= rd_en. Data appears 1 cycle after rd_en (small_fifo semantics).
- Source decode: s = in_data[IOQ_SRC_PORT_POS+:16]. Odd s means the packet came from the CPU.
- A packet is a drop if s >= 2*NUM_PORT_PAIRS, or if enable[s>>1]==0. The decision is sampled on the IOQ header word only.
- Destination rewrite (IOQ header word, packet not dropped):
  - loopback=1: dst = 1<<s.
  - CPU source: dst = 1<<(s-1).
  - MAC source: dst = 1<<(s+1).
  - Upper bits of the 16-bit field are zero.
- FSM states: HDRS, PKT, DROP.
  - HDRS: on an IOQ header word that is a drop, go to DROP and do not write the word. On in_wr && in_ctrl==0, go to PKT.
  - PKT: on in_wr && in_ctrl!=0 (EOP), go to HDRS and increment fwd_cnt.
  - DROP: suppress all writes. On in_wr && in_ctrl!=0 after the first data word, go to HDRS and increment drop_cnt. A drop decision must never cut off a packet that is already in progress.
- Non-IOQ module headers pass through unmodified. FIFO write = in_wr && !(dropping).
- Counters are 32-bit and wrap 0xFFFFFFFF->0.
- Register map, by offset:
  - 0 CTRL, RW: bit0 = loopback; bits[8+:NUM_PORT_PAIRS] = enable.
  - 1 FWD_CNT, RO.
  - 2 DROP_CNT, RO.
  - 3 CLR, WO: any write zeroes both counters.
  - Unimplemented CTRL bits read 0.
- Register protocol: a hit is reg_req_in && !reg_ack_in && tag match.
  - On a hit: one cycle later reg_ack_out=1 and the other fields are forwarded.
  - Hit read: reg_data_out = register value.
  - Hit write: register is updated and reg_data_out = reg_data_in.
  - Undefined offset: read returns 32'hDEADBEEF.
  - Non-hits are forwarded unchanged with 1-cycle latency.
- A CTRL change takes effect at the next IOQ header word. A packet already in progress keeps its decision.
- CLR and an increment in the same cycle: the counter becomes 1 (the event is not lost).
- Backpressure: upstream must honour in_rdy. Writing into a full FIFO is undefined. The bench asserts this never happens.
- Reset mid-packet: the FIFO is flushed, FSM goes to HDRS, and the remainder of the packet is treated as new input.

Decomposition:
- Shared package (nic_pkg): IOQ_* positions, IO_QUEUE_STAGE_NUM, register offsets, the DEADBEEF constant, FSM state encodings.
- Sub-module: small_fifo (existing, reused).
- Register decode and counters go in nic_port_map_regs. Datapath and FSM stay in the top module.

Test Plan:
- MAC port 0 packet (s=0, 3 words): out header dst=16'h0002, fwd_cnt=1.
- CPU port 5 packet with NUM_PORT_PAIRS=4: dst=16'h0010.
- Write CTRL=0x0000_0F01 (loopback), then send s=2: dst=16'h0004.
- Write CTRL=0x0000_0E00, then send s=1: no out_wr for the whole packet, drop_cnt=1. Then send s=9: drop_cnt=2.
- Hold out_rdy=0 while sending 6 words: in_rdy deasserts before overflow. Release: all words arrive in order and unmodified except the header.
- Write CLR in the same cycle as an EOP: fwd_cnt reads 1. Read offset 3: returns 0xDEADBEEF. A non-matching address is forwarded with ack unchanged.

Source files
------------

// File: rtl/nic_pkg.sv
// Shared constants for the NIC port-map lookup: IOQ header layout, register
// offsets, FSM encoding and the MAC<->CPU destination mapping.
package nic_pkg;

  localparam logic [7:0]  NIC_IO_QUEUE_STAGE_NUM = 8'hFF;
  localparam int          NIC_IOQ_SRC_PORT_POS   = 16;
  localparam int          NIC_IOQ_DST_PORT_POS   = 48;

  localparam int          OFF_CTRL     = 0;
  localparam int          OFF_FWD_CNT  = 1;
  localparam int          OFF_DROP_CNT = 2;
  localparam int          OFF_CLR      = 3;
  localparam logic [31:0] REG_BAD_RD   = 32'hDEAD_BEEF;

  typedef enum logic [1:0] {
    HDRS = 2'd0,
    PKT  = 2'd1,
    DROP = 2'd2
  } state_t;

  // Even ports are MACs, odd ports are their CPU DMA partners.
  function automatic logic [15:0] map_dst(input logic [15:0] src, input logic loopback);
    logic [15:0] tgt;
    if (loopback)    tgt = src;
    else if (src[0]) tgt = src - 16'd1;
    else             tgt = src + 16'd1;
    return 16'd1 << tgt;
  endfunction

endpackage

// File: rtl/nic_port_map_regs.sv
// Register-chain slave for the port-map lookup: CTRL, forward/drop counters, CLR.
// Every chain field is re-registered, so hits and non-hits both take one cycle.
module nic_port_map_regs import nic_pkg::*; #(
  parameter int          UDP_REG_SRC_WIDTH = 2,
  parameter int          NUM_PORT_PAIRS    = 4,
  parameter logic [29:0] BLOCK_ADDR        = '0,
  parameter int          REG_ADDR_BITS     = 2
) (
  input  logic                         clk,
  input  logic                         reset,
  input  logic                         reg_req_in,
  input  logic                         reg_ack_in,
  input  logic                         reg_rd_wr_L_in,
  input  logic [29:0]                  reg_addr_in,
  input  logic [31:0]                  reg_data_in,
  input  logic [UDP_REG_SRC_WIDTH-1:0] reg_src_in,
  output logic                         reg_req_out,
  output logic                         reg_ack_out,
  output logic                         reg_rd_wr_L_out,
  output logic [29:0]                  reg_addr_out,
  output logic [31:0]                  reg_data_out,
  output logic [UDP_REG_SRC_WIDTH-1:0] reg_src_out,
  input  logic                         fwd_inc,
  input  logic                         drop_inc,
  output logic                         loopback,
  output logic [NUM_PORT_PAIRS-1:0]    enable
);

  logic [31:0]              fwd_cnt, drop_cnt, ctrl_val, rd_val;
  logic [REG_ADDR_BITS-1:0] off;
  logic                     hit, wr_hit, clr;

  assign off      = reg_addr_in[REG_ADDR_BITS-1:0];
  assign hit      = reg_req_in && !reg_ack_in &&
                    (reg_addr_in[29:REG_ADDR_BITS] == BLOCK_ADDR[29-REG_ADDR_BITS:0]);
  assign wr_hit   = hit && !reg_rd_wr_L_in;
  assign clr      = wr_hit && (off == REG_ADDR_BITS'(OFF_CLR));
  assign ctrl_val = (32'(enable) << 8) | 32'(loopback);

  always_comb begin
    rd_val = REG_BAD_RD;
    case (off)
      REG_ADDR_BITS'(OFF_CTRL):     rd_val = ctrl_val;
      REG_ADDR_BITS'(OFF_FWD_CNT):  rd_val = fwd_cnt;
      REG_ADDR_BITS'(OFF_DROP_CNT): rd_val = drop_cnt;
      default:                      rd_val = REG_BAD_RD;
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      reg_req_out     <= 1'b0;
      reg_ack_out     <= 1'b0;
      reg_rd_wr_L_out <= 1'b0;
      reg_addr_out    <= '0;
      reg_data_out    <= '0;
      reg_src_out     <= '0;
      loopback        <= 1'b0;
      enable          <= '1;
      fwd_cnt         <= '0;
      drop_cnt        <= '0;
    end else begin
      reg_req_out     <= reg_req_in;
      reg_ack_out     <= reg_ack_in || hit;
      reg_rd_wr_L_out <= reg_rd_wr_L_in;
      reg_addr_out    <= reg_addr_in;
      reg_src_out     <= reg_src_in;
      reg_data_out    <= (hit && reg_rd_wr_L_in) ? rd_val : reg_data_in;
      if (wr_hit && off == REG_ADDR_BITS'(OFF_CTRL)) begin
        loopback <= reg_data_in[0];
        enable   <= reg_data_in[8 +: NUM_PORT_PAIRS];
      end
      // A clear coinciding with an event still counts that event.
      fwd_cnt  <= (clr ? 32'd0 : fwd_cnt)  + 32'(fwd_inc);
      drop_cnt <= (clr ? 32'd0 : drop_cnt) + 32'(drop_inc);
    end
  end

endmodule

// File: rtl/small_fifo.sv
// Generic synchronous FIFO, read data registered one cycle after rd_en.
// nearly_full raises with one free entry left; writing while full is not allowed.
module small_fifo #(
  parameter int WIDTH          = 72,
  parameter int MAX_DEPTH_BITS = 2
) (
  input  logic             clk,
  input  logic             reset,
  input  logic [WIDTH-1:0] din,
  input  logic             wr_en,
  input  logic             rd_en,
  output logic [WIDTH-1:0] dout,
  output logic             nearly_full,
  output logic             empty
);

  localparam int DEPTH = 1 << MAX_DEPTH_BITS;

  logic [WIDTH-1:0]          mem [DEPTH];
  logic [MAX_DEPTH_BITS-1:0] wr_ptr, rd_ptr;
  logic [MAX_DEPTH_BITS:0]   depth;

  always_ff @(posedge clk) begin
    if (wr_en) mem[wr_ptr] <= din;
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      depth  <= '0;
      dout   <= '0;
    end else begin
      if (wr_en) wr_ptr <= wr_ptr + MAX_DEPTH_BITS'(1);
      if (rd_en) begin
        dout   <= mem[rd_ptr];
        rd_ptr <= rd_ptr + MAX_DEPTH_BITS'(1);
      end
      if (wr_en && !rd_en)      depth <= depth + (MAX_DEPTH_BITS+1)'(1);
      else if (!wr_en && rd_en) depth <= depth - (MAX_DEPTH_BITS+1)'(1);
    end
  end

  assign nearly_full = depth >= (MAX_DEPTH_BITS+1)'(DEPTH - 1);
  assign empty       = depth == '0;

endmodule

// File: rtl/nic_port_map_lookup.sv
// Output-port lookup: rewrites the IOQ destination one-hot to pair MAC/CPU ports, drops bad sources.
// Output is a FIFO (1 cycle rd_en->data); in_rdy drops when the FIFO is nearly full.
module nic_port_map_lookup import nic_pkg::*; #(
  parameter int          DATA_WIDTH         = 64,
  parameter int          CTRL_WIDTH         = DATA_WIDTH / 8,
  parameter int          UDP_REG_SRC_WIDTH  = 2,
  parameter int          NUM_PORT_PAIRS     = 4,
  parameter logic [7:0]  IO_QUEUE_STAGE_NUM = NIC_IO_QUEUE_STAGE_NUM,
  parameter int          IOQ_SRC_PORT_POS   = NIC_IOQ_SRC_PORT_POS,
  parameter int          IOQ_DST_PORT_POS   = NIC_IOQ_DST_PORT_POS,
  parameter int          FIFO_DEPTH_BITS    = 2,
  parameter logic [29:0] BLOCK_ADDR         = '0,
  parameter int          REG_ADDR_BITS      = 2
) (
  input  logic                         clk,
  input  logic                         reset,
  input  logic [DATA_WIDTH-1:0]        in_data,
  input  logic [CTRL_WIDTH-1:0]        in_ctrl,
  input  logic                         in_wr,
  output logic                         in_rdy,
  output logic [DATA_WIDTH-1:0]        out_data,
  output logic [CTRL_WIDTH-1:0]        out_ctrl,
  output logic                         out_wr,
  input  logic                         out_rdy,
  input  logic                         reg_req_in,
  input  logic                         reg_ack_in,
  input  logic                         reg_rd_wr_L_in,
  input  logic [29:0]                  reg_addr_in,
  input  logic [31:0]                  reg_data_in,
  input  logic [UDP_REG_SRC_WIDTH-1:0] reg_src_in,
  output logic                         reg_req_out,
  output logic                         reg_ack_out,
  output logic                         reg_rd_wr_L_out,
  output logic [29:0]                  reg_addr_out,
  output logic [31:0]                  reg_data_out,
  output logic [UDP_REG_SRC_WIDTH-1:0] reg_src_out
);

  state_t                         state, state_nxt;
  logic                           seen_data, seen_data_nxt;
  logic                           loopback, fwd_inc, drop_inc;
  logic [NUM_PORT_PAIRS-1:0]      enable;
  logic [7:0]                     en_ext;
  logic [15:0]                    src;
  logic                           is_ioq, is_data, is_drop;
  logic [DATA_WIDTH-1:0]          hdr_data;
  logic                           fifo_wr, fifo_rd, fifo_nearly_full, fifo_empty;
  logic [CTRL_WIDTH+DATA_WIDTH-1:0] fifo_din;

  assign src     = in_data[IOQ_SRC_PORT_POS +: 16];
  assign is_ioq  = in_ctrl == CTRL_WIDTH'(IO_QUEUE_STAGE_NUM);
  assign is_data = in_ctrl == '0;
  assign en_ext  = 8'(enable);
  assign is_drop = (src >= 16'(2 * NUM_PORT_PAIRS)) || !en_ext[src[3:1]];

  always_comb begin
    hdr_data = in_data;
    hdr_data[IOQ_DST_PORT_POS +: 16] = map_dst(src, loopback);
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state     <= HDRS;
      seen_data <= 1'b0;
    end else begin
      state     <= state_nxt;
      seen_data <= seen_data_nxt;
    end
  end

  // DROP waits for a data word first so a module header cannot end the drop early.
  always_comb begin
    state_nxt     = state;
    seen_data_nxt = 1'b0;
    unique case (state)
      HDRS: begin
        if (in_wr && is_ioq && is_drop) state_nxt = DROP;
        else if (in_wr && is_data)      state_nxt = PKT;
      end
      PKT: begin
        if (in_wr && !is_data) state_nxt = HDRS;
      end
      DROP: begin
        seen_data_nxt = seen_data || (in_wr && is_data);
        if (in_wr && !is_data && seen_data) state_nxt = HDRS;
      end
      default: state_nxt = HDRS;
    endcase
  end

  always_comb begin
    fifo_wr  = 1'b0;
    fifo_din = {in_ctrl, in_data};
    fwd_inc  = 1'b0;
    drop_inc = 1'b0;
    unique case (state)
      HDRS: begin
        fifo_wr = in_wr && !(is_ioq && is_drop);
        if (is_ioq) fifo_din = {in_ctrl, hdr_data};
      end
      PKT: begin
        fifo_wr = in_wr;
        fwd_inc = in_wr && !is_data;
      end
      DROP: begin
        drop_inc = in_wr && !is_data && seen_data;
      end
      default: fifo_wr = 1'b0;
    endcase
  end

  assign fifo_rd = out_rdy && !fifo_empty;
  assign in_rdy  = !fifo_nearly_full;

  always_ff @(posedge clk) begin
    if (reset) out_wr <= 1'b0;
    else       out_wr <= fifo_rd;
  end

  small_fifo #(
    .WIDTH          (CTRL_WIDTH + DATA_WIDTH),
    .MAX_DEPTH_BITS (FIFO_DEPTH_BITS)
  ) u_fifo (
    .clk         (clk),
    .reset       (reset),
    .din         (fifo_din),
    .wr_en       (fifo_wr),
    .rd_en       (fifo_rd),
    .dout        ({out_ctrl, out_data}),
    .nearly_full (fifo_nearly_full),
    .empty       (fifo_empty)
  );

  nic_port_map_regs #(
    .UDP_REG_SRC_WIDTH (UDP_REG_SRC_WIDTH),
    .NUM_PORT_PAIRS    (NUM_PORT_PAIRS),
    .BLOCK_ADDR        (BLOCK_ADDR),
    .REG_ADDR_BITS     (REG_ADDR_BITS)
  ) u_regs (
    .clk             (clk),
    .reset           (reset),
    .reg_req_in      (reg_req_in),
    .reg_ack_in      (reg_ack_in),
    .reg_rd_wr_L_in  (reg_rd_wr_L_in),
    .reg_addr_in     (reg_addr_in),
    .reg_data_in     (reg_data_in),
    .reg_src_in      (reg_src_in),
    .reg_req_out     (reg_req_out),
    .reg_ack_out     (reg_ack_out),
    .reg_rd_wr_L_out (reg_rd_wr_L_out),
    .reg_addr_out    (reg_addr_out),
    .reg_data_out    (reg_data_out),
    .reg_src_out     (reg_src_out),
    .fwd_inc         (fwd_inc),
    .drop_inc        (drop_inc),
    .loopback        (loopback),
    .enable          (enable)
  );

endmodule

// File: tb/tb_nic_port_map_lookup.sv
// Directed bench for nic_port_map_lookup: vector table of CTRL/source cases plus
// hand-written sequences for backpressure, clear-vs-EOP, register chain and reset.
module tb_nic_port_map_lookup;

  logic        clk = 1'b0;
  logic        reset;
  logic [63:0] in_data, out_data;
  logic [7:0]  in_ctrl, out_ctrl;
  logic        in_wr, in_rdy, out_wr, out_rdy;
  logic        reg_req_in, reg_ack_in, reg_rd_wr_L_in;
  logic [29:0] reg_addr_in, reg_addr_out;
  logic [31:0] reg_data_in, reg_data_out;
  logic [1:0]  reg_src_in, reg_src_out;
  logic        reg_req_out, reg_ack_out, reg_rd_wr_L_out;

  always #5 clk = ~clk;

  nic_port_map_lookup dut (
    .clk(clk), .reset(reset),
    .in_data(in_data), .in_ctrl(in_ctrl), .in_wr(in_wr), .in_rdy(in_rdy),
    .out_data(out_data), .out_ctrl(out_ctrl), .out_wr(out_wr), .out_rdy(out_rdy),
    .reg_req_in(reg_req_in), .reg_ack_in(reg_ack_in), .reg_rd_wr_L_in(reg_rd_wr_L_in),
    .reg_addr_in(reg_addr_in), .reg_data_in(reg_data_in), .reg_src_in(reg_src_in),
    .reg_req_out(reg_req_out), .reg_ack_out(reg_ack_out), .reg_rd_wr_L_out(reg_rd_wr_L_out),
    .reg_addr_out(reg_addr_out), .reg_data_out(reg_data_out), .reg_src_out(reg_src_out)
  );

  typedef struct {
    logic [31:0] ctrl;
    logic [15:0] src;
    logic        drop;
    logic [15:0] dst;
  } vec_t;

  vec_t        vecs[11];
  int          checks = 0, errors = 0, ovf = 0;
  int          exp_fwd, exp_drop, wait_cnt;
  logic [71:0] outq[$];
  logic [31:0] rdv;
  logic        ackv, saw_low;

  always @(negedge clk) begin
    if (out_wr) outq.push_back({out_ctrl, out_data});
    if (in_wr && !in_rdy) ovf++;
  end

  initial begin
    #2000000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1);
  end

  task automatic check(input string name, input logic [71:0] act, input logic [71:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic put_word(input logic [7:0] c, input logic [63:0] d);
    int budget;
    budget = 200;
    in_wr = 1'b0;
    while (!in_rdy && budget > 0) begin
      tick();
      budget--;
    end
    if (!in_rdy) begin
      checks++;
      errors++;
      $display("FAIL in_rdy_timeout: in_rdy=0 expected 1");
    end else begin
      in_ctrl = c;
      in_data = d;
      in_wr   = 1'b1;
      tick();
      in_wr   = 1'b0;
    end
  endtask

  function automatic logic [63:0] hdr_word(input logic [15:0] s);
    return {16'hABCD, 16'h1234, s, 16'h5A5A};
  endfunction

  task automatic send_pkt(input logic [15:0] s, input int n, input logic [63:0] base);
    put_word(8'hFF, hdr_word(s));
    for (int k = 1; k < n - 1; k++) put_word(8'h00, base + 64'(k));
    put_word(8'h80, base + 64'(n - 1));
  endtask

  task automatic reg_access(input logic rd, input logic [29:0] addr, input logic [31:0] wdata,
                            input logic ack_in, output logic [31:0] rdata, output logic ack);
    reg_req_in = 1'b1; reg_ack_in = ack_in; reg_rd_wr_L_in = rd;
    reg_addr_in = addr; reg_data_in = wdata; reg_src_in = 2'd1;
    tick();
    rdata = reg_data_out;
    ack   = reg_ack_out;
    reg_req_in = 1'b0; reg_ack_in = 1'b0; reg_rd_wr_L_in = 1'b0;
    reg_addr_in = '0; reg_data_in = '0; reg_src_in = '0;
  endtask

  initial begin
    vecs[0]  = '{32'h0000_0F00, 16'd0, 1'b0, 16'h0002};
    vecs[1]  = '{32'h0000_0F00, 16'd5, 1'b0, 16'h0010};
    vecs[2]  = '{32'h0000_0F01, 16'd2, 1'b0, 16'h0004};
    vecs[3]  = '{32'h0000_0E00, 16'd1, 1'b1, 16'h0000};
    vecs[4]  = '{32'h0000_0E00, 16'd9, 1'b1, 16'h0000};
    vecs[5]  = '{32'h0000_0F00, 16'd6, 1'b0, 16'h0080};
    vecs[6]  = '{32'h0000_0F00, 16'd7, 1'b0, 16'h0040};
    vecs[7]  = '{32'h0000_0F01, 16'd7, 1'b0, 16'h0080};
    vecs[8]  = '{32'h0000_0700, 16'd6, 1'b1, 16'h0000};
    vecs[9]  = '{32'h0000_0F00, 16'd8, 1'b1, 16'h0000};
    vecs[10] = '{32'h0000_0F00, 16'd3, 1'b0, 16'h0004};

    reset = 1'b1; in_data = '0; in_ctrl = '0; in_wr = 1'b0; out_rdy = 1'b1;
    reg_req_in = 1'b0; reg_ack_in = 1'b0; reg_rd_wr_L_in = 1'b0;
    reg_addr_in = '0; reg_data_in = '0; reg_src_in = '0;
    repeat (3) tick();
    reset = 1'b0;

    // Reset state
    check("rst_out_wr", out_wr, 0);
    check("rst_in_rdy", in_rdy, 1);
    check("rst_reg_ack_out", reg_ack_out, 0);
    check("rst_reg_data_out", reg_data_out, 0);
    reg_access(1'b1, 30'd0, 32'd0, 1'b0, rdv, ackv);
    check("rst_ctrl", rdv, 32'h0000_0F00);
    check("rd_ack", ackv, 1);
    reg_access(1'b1, 30'd1, 32'd0, 1'b0, rdv, ackv);
    check("rst_fwd_cnt", rdv, 0);
    reg_access(1'b1, 30'd2, 32'd0, 1'b0, rdv, ackv);
    check("rst_drop_cnt", rdv, 0);

    // Vector table: CTRL setting, source port, expected outcome
    exp_fwd = 0;
    exp_drop = 0;
    for (int i = 0; i < 11; i++) begin
      reg_access(1'b0, 30'd0, vecs[i].ctrl, 1'b0, rdv, ackv);
      outq.delete();
      send_pkt(vecs[i].src, 3, 64'h1000 * 64'(i + 1));
      repeat (8) tick();
      if (vecs[i].drop) exp_drop++;
      else exp_fwd++;
      check($sformatf("v%0d_nwords", i), outq.size(), vecs[i].drop ? 0 : 3);
      if (!vecs[i].drop && outq.size() == 3) begin
        check($sformatf("v%0d_hdr", i), outq[0],
              {8'hFF, vecs[i].dst, 16'h1234, vecs[i].src, 16'h5A5A});
        check($sformatf("v%0d_data", i), outq[1], {8'h00, 64'h1000 * 64'(i + 1) + 64'd1});
        check($sformatf("v%0d_eop", i), outq[2], {8'h80, 64'h1000 * 64'(i + 1) + 64'd2});
      end
      reg_access(1'b1, 30'd1, 32'd0, 1'b0, rdv, ackv);
      check($sformatf("v%0d_fwd_cnt", i), rdv, 32'(exp_fwd));
      reg_access(1'b1, 30'd2, 32'd0, 1'b0, rdv, ackv);
      check($sformatf("v%0d_drop_cnt", i), rdv, 32'(exp_drop));
    end

    // Backpressure: 6-word packet into a 4-deep FIFO with the output stalled
    reg_access(1'b0, 30'd0, 32'h0000_0F00, 1'b0, rdv, ackv);
    outq.delete();
    out_rdy = 1'b0;
    saw_low = 1'b0;
    fork
      send_pkt(16'd4, 6, 64'hB000);
      begin
        wait_cnt = 0;
        while (in_rdy && wait_cnt < 50) begin
          tick();
          wait_cnt++;
        end
        saw_low = !in_rdy;
        repeat (4) tick();
        out_rdy = 1'b1;
      end
    join
    repeat (10) tick();
    check("bp_in_rdy_low", saw_low, 1);
    check("bp_nwords", outq.size(), 6);
    if (outq.size() == 6) begin
      check("bp_hdr", outq[0], {8'hFF, 16'h0020, 16'h1234, 16'd4, 16'h5A5A});
      for (int k = 1; k < 5; k++)
        check($sformatf("bp_data%0d", k), outq[k], {8'h00, 64'hB000 + 64'(k)});
      check("bp_eop", outq[5], {8'h80, 64'hB005});
    end

    // CLR written in the same cycle as an EOP
    put_word(8'hFF, hdr_word(16'd0));
    put_word(8'h00, 64'hC0DE);
    in_ctrl = 8'h80; in_data = 64'hC0DF; in_wr = 1'b1;
    reg_req_in = 1'b1; reg_rd_wr_L_in = 1'b0; reg_addr_in = 30'd3; reg_data_in = 32'd0;
    tick();
    in_wr = 1'b0; reg_req_in = 1'b0; reg_addr_in = '0;
    check("clr_ack", reg_ack_out, 1);
    reg_access(1'b1, 30'd1, 32'd0, 1'b0, rdv, ackv);
    check("clr_eop_fwd_cnt", rdv, 32'd1);
    reg_access(1'b1, 30'd2, 32'd0, 1'b0, rdv, ackv);
    check("clr_drop_cnt", rdv, 32'd0);

    // Register map corners
    reg_access(1'b1, 30'd3, 32'd0, 1'b0, rdv, ackv);
    check("rd_clr_offset", rdv, 32'hDEAD_BEEF);
    reg_access(1'b0, 30'd0, 32'hFFFF_FFFF, 1'b0, rdv, ackv);
    check("wr_echo_data", rdv, 32'hFFFF_FFFF);
    reg_access(1'b1, 30'd0, 32'd0, 1'b0, rdv, ackv);
    check("ctrl_unimpl_bits", rdv, 32'h0000_0F01);
    reg_access(1'b1, 30'h4, 32'h1234_5678, 1'b0, rdv, ackv);
    check("miss_ack", ackv, 0);
    check("miss_data", rdv, 32'h1234_5678);
    check("miss_req", reg_req_out, 1);
    check("miss_addr", reg_addr_out, 30'h4);
    check("miss_rd_wr_L", reg_rd_wr_L_out, 1);
    check("miss_src", reg_src_out, 2'd1);
    reg_access(1'b1, 30'd1, 32'hCAFE_F00D, 1'b1, rdv, ackv);
    check("acked_fwd_ack", ackv, 1);
    check("acked_fwd_data", rdv, 32'hCAFE_F00D);

    // Reset in the middle of a packet
    out_rdy = 1'b0;
    put_word(8'hFF, hdr_word(16'd0));
    put_word(8'h00, 64'hD001);
    reset = 1'b1;
    repeat (2) tick();
    reset = 1'b0;
    outq.delete();
    out_rdy = 1'b1;
    put_word(8'h00, 64'hD002);
    put_word(8'h80, 64'hD003);
    repeat (8) tick();
    check("mid_rst_nwords", outq.size(), 2);
    if (outq.size() == 2) begin
      check("mid_rst_w0", outq[0], {8'h00, 64'hD002});
      check("mid_rst_w1", outq[1], {8'h80, 64'hD003});
    end
    reg_access(1'b1, 30'd1, 32'd0, 1'b0, rdv, ackv);
    check("mid_rst_fwd_cnt", rdv, 32'd1);
    reg_access(1'b1, 30'd0, 32'd0, 1'b0, rdv, ackv);
    check("mid_rst_ctrl", rdv, 32'h0000_0F00);

    check("no_overflow", ovf, 0);
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
